row_ring_writer: RTL and testbench
==================================

ROW_RING_WRITER -- requirements
Module: row_ring_writer

Interface
REQ-001 SHALL have parameter COLS, default 16, pixels per row (2..256).
REQ-002 SHALL have parameter DW, default 8, pixel data width.
REQ-003 SHALL have parameter COL_W, default 4, column counter width, equal to clog2(COLS).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous restart to reset state.
REQ-007 in_valid  input  1  upstream pixel valid.
REQ-008 in_ready  output  1  pixel accepted this cycle when high with in_valid.
REQ-009 in_data  input  DW  pixel value.
REQ-010 wr_en  output  1  row-buffer write strobe.
REQ-011 wr_row  output  3  destination slot, 0..4.
REQ-012 wr_col  output  COL_W  destination column.
REQ-013 wr_data  output  DW  write data.
REQ-014 rd_inc  input  1  reader advanced its 3-row window; oldest stored row released.
REQ-015 win_valid  output  1  at least 3 complete rows stored.
REQ-016 row_cnt  output  3  complete, unreleased rows, 0..5.
REQ-017 row_done  output  1  one-cycle pulse, cycle after a row's last pixel is written.
REQ-018 err  output  1  sticky, rd_inc received while win_valid low.

Function
REQ-019 Writer end of the 5-slot row ring whose reader walks prev/cur/next slot indices mod 5; both ends SHALL advance slots 0,1,2,3,4,0.
REQ-020 Accept = in_valid & in_ready; in_ready SHALL be (row_cnt < 5), combinational from registers only, independent of in_valid.
REQ-021 wr_en = accept; wr_data = in_data; wr_row/wr_col = current pointer registers; zero-cycle write latency.
REQ-022 On accept with wr_col < COLS-1: wr_col +1, wr_row held.
REQ-023 On accept with wr_col == COLS-1: wr_col -> 0; wr_row -> 0 if 4, else +1; row completes.
REQ-024 row_cnt next = row_cnt + (row completes) - (rd_inc & win_valid); simultaneous complete and valid release SHALL leave row_cnt unchanged.
REQ-025 row_cnt SHALL never exceed 5: in_ready low at 5 blocks completion.
REQ-026 win_valid = (row_cnt >= 3), combinational from row_cnt register.
REQ-027 rd_inc while win_valid low SHALL be ignored for row_cnt and SHALL set err until reset/clr.
REQ-028 row_done registered: high exactly one cycle after the completing accept.
REQ-029 in_valid low SHALL freeze all pointers; partial rows are resumed, never discarded.
REQ-030 clr SHALL take priority over accept and rd_inc in the same cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force wr_row=0, wr_col=0, row_cnt=0, row_done=0, err=0; hence in_ready=1, win_valid=0, wr_en follows in_valid.
REQ-032 clr high SHALL produce the same register values at the next edge; mid-row reset/clr SHALL abandon the partial row.

Structure
REQ-033 Shared package SHALL hold ROW_SLOTS=5, WIN_ROWS=3, SLOT_W=3, and the slot-increment wrap function.
REQ-034 One sub-module, ring_ptr5 (mod-5 slot pointer with inc and sync clear), SHALL implement wr_row.
REQ-035 Column counter, occupancy counter and error flag SHALL live in row_ring_writer.

Verification (COLS=4)
REQ-036 Reset, 12 accepted pixels, no rd_inc -> wr_row 0,1,2 each for 4 beats; row_done after beats 4,8,12; win_valid high after beat 12; row_cnt=3.
REQ-037 Stream 20 pixels continuously, no rd_inc -> row_cnt=5, in_ready low after beat 20; wr_row back to 0 with wr_col=0; beat 21 stalls, no wr_en.
REQ-038 From row_cnt=5, pulse rd_inc once -> row_cnt=4, in_ready high next cycle; next 4 beats write slot 0.
REQ-039 row_cnt=3, completing beat coincides with rd_inc -> row_cnt stays 3, row_done pulses, win_valid stays high.
REQ-040 rd_inc at row_cnt=2 -> row_cnt stays 2, err=1 and holds; clr -> err=0, all pointers 0.
REQ-041 Deassert rst_n mid-row (wr_col=2) between edges -> outputs zero immediately without a clock edge; next accept writes slot 0 column 0.

Source files
------------

// File: rtl/row_ring_writer_pkg.sv
// Shared constants and helpers for the 5-slot row ring.
package row_ring_writer_pkg;

   localparam int unsigned ROW_SLOTS = 5;
   localparam int unsigned WIN_ROWS  = 3;
   localparam int unsigned SLOT_W    = 3;

   // Advance a slot index 0,1,2,3,4,0,...
   function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] slot);
      logic [SLOT_W-1:0] nxt;
      if (slot == SLOT_W'(ROW_SLOTS - 1)) begin
         nxt = '0;
      end else begin
         nxt = slot + SLOT_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/row_ring_writer_ring_ptr5.sv
// Mod-5 slot pointer with increment and synchronous clear.
module ring_ptr5
   import row_ring_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [SLOT_W-1:0] ptr
);

   logic [SLOT_W-1:0] ptr_q;
   logic [SLOT_W-1:0] ptr_d;

   // Next pointer: clear wins over increment.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = slot_inc(ptr_q);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/row_ring_writer.sv
// Writer end of a 5-slot row ring: places incoming pixels row by row into
// the ring and tracks how many complete rows the reader has not yet released.
module row_ring_writer
   import row_ring_writer_pkg::*;
#(
   parameter int unsigned COLS  = 16,
   parameter int unsigned DW    = 8,
   parameter int unsigned COL_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             wr_en,
   output logic [2:0]       wr_row,
   output logic [COL_W-1:0] wr_col,
   output logic [DW-1:0]    wr_data,
   input  logic             rd_inc,
   output logic             win_valid,
   output logic [2:0]       row_cnt,
   output logic             row_done,
   output logic             err
);

   localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);

   logic [COL_W-1:0]  col_q, col_d;
   logic [SLOT_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              accept;
   logic              row_complete;
   logic              row_release;
   logic [SLOT_W-1:0] slot;

   // Full ring (all 5 slots hold unreleased rows) back-pressures upstream.
   assign in_ready     = (cnt_q < SLOT_W'(ROW_SLOTS));
   assign win_valid    = (cnt_q >= SLOT_W'(WIN_ROWS));
   assign accept       = in_valid & in_ready;
   assign row_complete = accept & (col_q == LastCol);
   // A release with no full window is ignored and flagged as an error.
   assign row_release  = rd_inc & win_valid;

   ring_ptr5 u_row_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (row_complete),
      .ptr   (slot)
   );

   // Next-state for column, occupancy, row_done pulse and sticky error.
   always_comb begin
      col_d  = col_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      err_d  = err_q;
      if (clr) begin
         col_d = '0;
         cnt_d = '0;
         err_d = 1'b0;
      end else begin
         if (accept) begin
            col_d = (col_q == LastCol) ? '0 : col_q + COL_W'(1);
         end
         if (row_complete && !row_release) begin
            cnt_d = cnt_q + SLOT_W'(1);
         end else if (!row_complete && row_release) begin
            cnt_d = cnt_q - SLOT_W'(1);
         end
         done_d = row_complete;
         if (rd_inc && !win_valid) begin
            err_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         col_q  <= col_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign wr_en    = accept;
   assign wr_row   = slot;
   assign wr_col   = col_q;
   assign wr_data  = in_data;
   assign row_cnt  = cnt_q;
   assign row_done = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_row_ring_writer.sv
// Randomised scoreboard bench for row_ring_writer with COLS=4.
module tb_row_ring_writer;

   localparam int COLS  = 4;
   localparam int DW    = 8;
   localparam int COL_W = 2;
   localparam int SLOTS = 5;

   logic             clk;
   logic             rst_n;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             wr_en;
   logic [2:0]       wr_row;
   logic [COL_W-1:0] wr_col;
   logic [DW-1:0]    wr_data;
   logic             rd_inc;
   logic             win_valid;
   logic [2:0]       row_cnt;
   logic             row_done;
   logic             err;

   row_ring_writer #(
      .COLS  (COLS),
      .DW    (DW),
      .COL_W (COL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .rd_inc    (rd_inc),
      .win_valid (win_valid),
      .row_cnt   (row_cnt),
      .row_done  (row_done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int row;
      int col;
      int data;
   } wr_t;

   typedef struct {
      int wr_en;
      int ready;
      int win;
      int cnt;
      int done;
      int err;
   } st_t;

   wr_t wr_q[$];
   st_t st_q[$];

   int total = 0;
   int bad   = 0;

   // Reference model: pixels accepted since reset and rows released.
   int pix;
   int rel;
   int err_m;
   int done_m;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one status entry per driven cycle, one write entry per wr_en.
   always @(negedge clk) begin
      st_t s;
      wr_t w;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         check("wr_en", int'(wr_en), s.wr_en);
         check("in_ready", int'(in_ready), s.ready);
         check("win_valid", int'(win_valid), s.win);
         check("row_cnt", int'(row_cnt), s.cnt);
         check("row_done", int'(row_done), s.done);
         check("err", int'(err), s.err);
         if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               w = wr_q.pop_front();
               check("wr_row", int'(wr_row), w.row);
               check("wr_col", int'(wr_col), w.col);
               check("wr_data", int'(wr_data), w.data);
            end
         end
      end
   end

   task automatic model_reset();
      pix    = 0;
      rel    = 0;
      err_m  = 0;
      done_m = 0;
   endtask

   // One clock cycle of stimulus; called at posedge+1.
   task automatic step(input bit v, input bit rdi, input bit c);
      int  cnt;
      bit  rdy;
      bit  win;
      bit  acc;
      bit  comp;
      st_t s;
      wr_t w;
      in_valid = v;
      rd_inc   = rdi;
      clr      = c;
      in_data  = DW'($urandom);
      cnt = pix / COLS - rel;
      rdy = (cnt < SLOTS);
      win = (cnt >= 3);
      acc = v && rdy;
      s.wr_en = int'(acc);
      s.ready = int'(rdy);
      s.win   = int'(win);
      s.cnt   = cnt;
      s.done  = done_m;
      s.err   = err_m;
      st_q.push_back(s);
      if (acc) begin
         w.row  = (pix / COLS) % SLOTS;
         w.col  = pix % COLS;
         w.data = int'(in_data);
         wr_q.push_back(w);
      end
      if (c) begin
         model_reset();
      end else begin
         comp = acc && (pix % COLS == COLS - 1);
         if (acc) pix++;
         if (rdi && win) rel++;
         if (rdi && !win) err_m = 1;
         done_m = int'(comp);
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset applied between edges, checked before any edge.
   task automatic async_reset();
      in_valid = 1'b0;
      rd_inc   = 1'b0;
      clr      = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst_wr_row", int'(wr_row), 0);
      check("rst_wr_col", int'(wr_col), 0);
      check("rst_row_cnt", int'(row_cnt), 0);
      check("rst_row_done", int'(row_done), 0);
      check("rst_err", int'(err), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_win_valid", int'(win_valid), 0);
      check("rst_wr_en", int'(wr_en), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n    = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b0;
      rd_inc   = 1'b0;
      in_data  = '0;
      model_reset();
      #2;
      async_reset();

      // Three rows into slots 0..2, then fill the ring to five rows.
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);               // stalls: ring full
      step(1'b0, 1'b1, 1'b0);               // release one row
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);  // refills slot 0
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);               // row_cnt now 3
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);               // completion coincides with release
      step(1'b0, 1'b0, 1'b0);

      // Illegal release below a full window, then clr.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);               // clr beats accept and rd_inc
      step(1'b0, 1'b0, 1'b0);

      // Mid-row asynchronous reset abandons the partial row.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      async_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 99) == 0));
      end
      in_valid = 1'b0;
      rd_inc   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      check("wr_queue_empty", wr_q.size(), 0);
      check("st_queue_empty", st_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
